// File: rtl/comp_serial_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : comp_serial_rx_pkg
//  Purpose : Shared state encoding for the bit-serial comparator receiver.
//            S_IDLE=0, S_SHIFT=1, S_DONE=2. Code 3 is unused and recovers
//            to S_IDLE in the FSM.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package comp_serial_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage : comp_serial_rx_pkg
`default_nettype wire

// File: rtl/comp_bit_cnt.sv
`default_nettype none
// ============================================================================
//  Module  : comp_bit_cnt
//  Purpose : Counts accepted bit pairs of one operand. Saturates at W-1 so
//            the count never leaves the 0..W-1 range inside a comparison.
//  Ports   : clk   in  clock, rising edge
//            rst   in  asynchronous active-high reset
//            clr   in  synchronous clear (start of a comparison)
//            en    in  one pair consumed this cycle
//            last  out count equals W-1 (next pair is the final one)
//  Rev     : 1.0  initial release
// ============================================================================
module comp_bit_cnt
  import comp_serial_rx_pkg::*;
#(
  parameter int W     = 2,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign last = (cnt_q == CNT_W'(W - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !last) begin
      // The final pair moves the FSM to DONE; holding here keeps cnt <= W-1.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : comp_bit_cnt
`default_nettype wire

// File: rtl/comp_serial_rx.sv
`default_nettype none
// ============================================================================
//  Module  : comp_serial_rx
//  Purpose : Bit-serial magnitude comparator. Receives two W-bit operands as
//            MSB-first (x_bit, y_bit) pairs under valid/ready and returns
//            eq/gt/lt under a second valid/ready handshake.
//  Ports   : clk        in  clock, rising edge
//            rst        in  asynchronous active-high reset
//            start      in  begin a comparison (IDLE, or DONE with handshake)
//            in_valid   in  x_bit/y_bit valid
//            in_ready   out pair accepted this cycle (high in SHIFT)
//            x_bit      in  operand x bit, MSB first
//            y_bit      in  operand y bit, MSB first
//            out_valid  out result valid (high in DONE)
//            out_ready  in  consumer accepts result
//            eq/gt/lt   out one-hot result while out_valid, else 0
//            busy       out high in SHIFT or DONE
//  Rev     : 1.0  initial release
// ============================================================================
module comp_serial_rx
  import comp_serial_rx_pkg::*;
#(
  parameter int W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  input  logic x_bit,
  input  logic y_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic eq,
  output logic gt,
  output logic lt,
  output logic busy
);

  localparam int CNT_W = $clog2(W + 1);

  state_e state_q, state_d;
  logic   decided_q, decided_d;
  logic   gt_q, gt_d;
  logic   lt_q, lt_d;
  logic   cnt_clr;
  logic   cnt_en;
  logic   cnt_last;

  comp_bit_cnt #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    decided_d = decided_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SHIFT;
          cnt_clr   = 1'b1;
          decided_d = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
        end
      end

      S_SHIFT: begin
        // in_ready is high throughout SHIFT, so in_valid alone means accept.
        if (in_valid) begin
          cnt_en = 1'b1;
          // The first differing MSB-first pair fixes the answer.
          if (!decided_q && (x_bit != y_bit)) begin
            gt_d      = x_bit;
            lt_d      = y_bit;
            decided_d = 1'b1;
          end
          if (cnt_last) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          cnt_clr   = 1'b1;
          decided_d = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
          state_d   = start ? S_SHIFT : S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        cnt_clr   = 1'b1;
        decided_d = 1'b0;
        gt_d      = 1'b0;
        lt_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      decided_q <= decided_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
    end
  end

  // Outputs decode straight from flops, so an async reset clears them at once.
  assign in_ready  = (state_q == S_SHIFT);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign eq        = out_valid && !decided_q;
  assign gt        = out_valid && gt_q;
  assign lt        = out_valid && lt_q;

endmodule : comp_serial_rx
`default_nettype wire

// File: tb/tb_comp_serial_rx.sv
`default_nettype none
// ============================================================================
//  Module  : tb_comp_serial_rx
//  Purpose : Self-checking bench for comp_serial_rx at W=2, W=1 and W=8.
//            Expected results come from integer comparison of the operands.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_comp_serial_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start;
  logic [2:0] in_valid;
  logic [2:0] x_bit;
  logic [2:0] y_bit;
  logic [2:0] out_ready;
  logic [2:0] in_ready;
  logic [2:0] out_valid;
  logic [2:0] eq;
  logic [2:0] gt;
  logic [2:0] lt;
  logic [2:0] busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] mon_x = 2'b00;
  logic [1:0] mon_y = 2'b00;

  always #5 clk = ~clk;

  comp_serial_rx #(.W(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .x_bit(x_bit[0]), .y_bit(y_bit[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .eq(eq[0]), .gt(gt[0]), .lt(lt[0]), .busy(busy[0])
  );

  comp_serial_rx #(.W(1)) u_dut_w1 (
    .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .x_bit(x_bit[1]), .y_bit(y_bit[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .eq(eq[1]), .gt(gt[1]), .lt(lt[1]), .busy(busy[1])
  );

  comp_serial_rx #(.W(8)) u_dut_w8 (
    .clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .x_bit(x_bit[2]), .y_bit(y_bit[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .eq(eq[2]), .gt(gt[2]), .lt(lt[2]), .busy(busy[2])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full comparison on DUT 'sel' of width 'w'. 'stall' idle cycles are
  // inserted between pairs, 'bp' cycles of out_ready=0 in DONE. With
  // from_shift the DUT is already in SHIFT; with chain the handshake carries
  // start=1 for a back-to-back comparison.
  task automatic compare(input int sel, input int w, input logic [63:0] xv,
                         input logic [63:0] yv, input int stall, input int bp,
                         input bit from_shift, input bit chain);
    logic [63:0] mask;
    logic [63:0] xm;
    logic [63:0] ym;
    logic [2:0]  exp_res;
    mask    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    xm      = xv & mask;
    ym      = yv & mask;
    exp_res = {xm == ym, xm > ym, xm < ym};

    if (!from_shift) begin
      @(negedge clk);
      start[sel] = 1'b1;
      @(negedge clk);
      start[sel] = 1'b0;
    end
    check("shift_entry", {busy[sel], in_ready[sel], out_valid[sel]}, 3'b110);

    for (int i = w - 1; i >= 0; i--) begin
      if (i != w - 1) begin
        repeat (stall) begin
          in_valid[sel] = 1'b0;
          x_bit[sel]    = 1'bx;
          y_bit[sel]    = 1'bx;
          start[sel]    = 1'($urandom_range(0, 1));
          @(negedge clk);
          check("stall_hold", {in_ready[sel], out_valid[sel]}, 2'b10);
        end
      end
      start[sel]    = 1'b0;
      in_valid[sel] = 1'b1;
      x_bit[sel]    = xm[i];
      y_bit[sel]    = ym[i];
      @(negedge clk);
      check("valid_timing", out_valid[sel], (i == 0));
    end
    in_valid[sel] = 1'b0;
    x_bit[sel]    = 1'bx;
    y_bit[sel]    = 1'bx;

    repeat (bp) begin
      out_ready[sel] = 1'b0;
      start[sel]     = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_hold", {out_valid[sel], eq[sel], gt[sel], lt[sel]}, {1'b1, exp_res});
    end
    start[sel] = 1'b0;

    check("result", {eq[sel], gt[sel], lt[sel]}, exp_res);

    out_ready[sel] = 1'b1;
    start[sel]     = chain;
    @(negedge clk);
    out_ready[sel] = 1'b0;
    start[sel]     = 1'b0;
    if (chain) begin
      check("b2b_shift", {busy[sel], in_ready[sel], out_valid[sel]}, 3'b110);
    end else begin
      check("to_idle", {busy[sel], in_ready[sel], out_valid[sel], eq[sel], gt[sel], lt[sel]}, 6'b0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = '0;
    in_valid  = '0;
    x_bit     = '0;
    y_bit     = '0;
    out_ready = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("reset_state", {busy[s], in_ready[s], out_valid[s], eq[s], gt[s], lt[s]}, 6'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Exhaustive W=2 sweep with random stalls and backpressure.
    $monitor("%0t x=%b y=%b eq=%b gt=%b lt=%b", $time, mon_x, mon_y, eq[0], gt[0], lt[0]);
    for (int xi = 0; xi < 4; xi++) begin
      for (int yi = 0; yi < 4; yi++) begin
        mon_x = 2'(xi);
        mon_y = 2'(yi);
        compare(0, 2, 64'(xi), 64'(yi), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), 1'b0, 1'b0);
      end
    end

    // Early decision must survive a contradicting second pair.
    compare(0, 2, 64'h2, 64'h1, 0, 0, 1'b0, 1'b0);

    // Long stalls and backpressure on equal operands.
    compare(0, 2, 64'h3, 64'h3, 3, 4, 1'b0, 1'b0);

    // Back-to-back: handshake with start=1 goes straight to SHIFT.
    compare(0, 2, 64'h3, 64'h0, 0, 1, 1'b0, 1'b1);
    compare(0, 2, 64'h0, 64'h1, 0, 0, 1'b1, 1'b0);

    // Asynchronous reset after the first pair clears outputs before any edge.
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0]    = 1'b0;
    in_valid[0] = 1'b1;
    x_bit[0]    = 1'b0;
    y_bit[0]    = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("pre_rst_busy", busy[0], 1'b1);
    #2 rst = 1'b1;
    #1 check("async_rst", {busy[0], in_ready[0], out_valid[0], eq[0], gt[0], lt[0]}, 6'b0);
    @(negedge clk);
    rst = 1'b0;
    compare(0, 2, 64'h1, 64'h0, 0, 0, 1'b0, 1'b0);

    // W=1 corner and full W=1 sweep.
    compare(1, 1, 64'h1, 64'h0, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      compare(1, 1, 64'(k >> 1), 64'(k & 1), 0, int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end

    // W=8 directed then random.
    compare(2, 8, 64'hA5, 64'hA5, 0, 0, 1'b0, 1'b0);
    compare(2, 8, 64'h7F, 64'h80, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      logic [63:0] a;
      logic [63:0] b;
      a = 64'($urandom_range(0, 255));
      b = ($urandom_range(0, 3) == 0) ? a : 64'($urandom_range(0, 255));
      compare(2, 8, a, b, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
              1'b0, 1'($urandom_range(0, 1)) && (k == 29) ? 1'b0 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_comp_serial_rx
`default_nettype wire
